dbg_loader: RTL and testbench

DBG_LOADER -- requirements
Module: dbg_loader

---
 rtl/dbg_loader.sv | 256 +++++++++++++++++++++++++
 tb/tb_dbg_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_loader.sv
// ---------------------------------------------------------------------------
// dbg_loader -- host-driven debug loader.
//
// Byte-oriented command engine sitting between a host UART and the CPU memory
// bus. Commands received in IDLE:
//   'W' (0x57) + 4 address bytes + 4 data bytes -> 32-bit write, reply 0x06
//   'R' (0x52) + 4 address bytes                -> 32-bit read, reply 4 bytes LE
//   'G' (0x47) release the CPU from reset, reply 0x06
//   'H' (0x48) hold the CPU in reset, reply 0x06
//   anything else                               -> reply 0x15
// Multi-byte fields are little-endian (first byte lands in bits 7:0).
//
// Optional feature: define DBG_LOADER_TIMEOUT_EN to abort an ADDR/DATA phase
// after TIMEOUT_CYCLES cycles without a byte (reply 0x15, no memory access).
//
// Parameters:
//   MEM_CYCLES     cycles o_dbg_mem_op stays high per access (>= 1)
//   TIMEOUT_CYCLES inter-byte timeout (only with DBG_LOADER_TIMEOUT_EN)
//   HOLD_ON_RESET  1 = CPU held in reset after block reset
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_rx_data, i_rx_valid   received host byte + one-cycle strobe
//   o_tx_data, o_tx_valid   response byte, held until i_tx_ready
//   i_tx_ready              transmitter accepts the byte
//   o_cpu_n_reset           active-low CPU reset
//   o_dbg_mem_op            debug port owns the memory bus
//   o_dbg_wren              byte write enables (F on write, 0 on read)
//   o_dbg_adr, o_dbg_do     access address / write data
//   i_dbg_di                read data, valid on the last o_dbg_mem_op cycle
// ---------------------------------------------------------------------------
module dbg_loader #(
    parameter int MEM_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int HOLD_ON_RESET  = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_cpu_n_reset,
    output logic        o_dbg_mem_op,
    output logic [3:0]  o_dbg_wren,
    output logic [31:0] o_dbg_adr,
    output logic [31:0] o_dbg_do,
    input  logic [31:0] i_dbg_di
);

    localparam int MCW = (MEM_CYCLES > 1) ? $clog2(MEM_CYCLES) : 1;
    localparam logic [MCW-1:0] MC_LAST = MCW'(MEM_CYCLES - 1);

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_G = 8'h47;
    localparam logic [7:0] CMD_H = 8'h48;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_MEM,
        S_RESP
    } state_t;

    state_t r_state, w_state_nxt;

    logic [1:0]     r_cnt;        // byte index within ADDR/DATA field
    logic           r_is_write;
    logic [31:0]    r_asm;        // little-endian shift-in assembler
    logic [31:0]    r_adr_hold;   // write address parked until data arrives
    logic [31:0]    r_adr;
    logic [31:0]    r_do;
    logic [MCW-1:0] r_mem_cnt;
    logic [31:0]    r_resp;       // response bytes, current byte in [7:0]
    logic [1:0]     r_resp_left;  // bytes remaining after the current one
    logic           r_cpu_n_reset;

    logic [31:0] w_asm_nxt;
    logic        w_field_done;
    logic        w_mem_done;
    logic        w_tx_acc;
    logic        w_resp_last;
    logic        w_timeout;

    // New byte enters at the top so after four bytes the first is in [7:0].
    assign w_asm_nxt    = {i_rx_data, r_asm[31:8]};
    assign w_field_done = i_rx_valid && (r_cnt == 2'd3);
    assign w_mem_done   = (r_mem_cnt == MC_LAST);
    assign w_tx_acc     = (r_state == S_RESP) && i_tx_ready;
    assign w_resp_last  = w_tx_acc && (r_resp_left == 2'd0);

`ifdef DBG_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_to_cnt;
    logic          w_in_field;

    assign w_in_field = (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_timeout  = w_in_field && !i_rx_valid && (r_to_cnt == TO_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_rx_valid || !w_in_field)
            r_to_cnt <= '0;
        else
            r_to_cnt <= r_to_cnt + 1'b1;
    end
`else
    logic w_unused_to;
    assign w_unused_to = ^TIMEOUT_CYCLES;
    assign w_timeout   = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state and bus/tx strobes
    always_comb begin
        w_state_nxt  = r_state;
        o_tx_valid   = 1'b0;
        o_dbg_mem_op = 1'b0;
        o_dbg_wren   = 4'h0;
        case (r_state)
            S_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_W || i_rx_data == CMD_R)
                        w_state_nxt = S_ADDR;
                    else
                        w_state_nxt = S_RESP;
                end
            end
            S_ADDR: begin
                if (w_timeout)
                    w_state_nxt = S_RESP;
                else if (w_field_done)
                    w_state_nxt = r_is_write ? S_DATA : S_MEM;
            end
            S_DATA: begin
                if (w_timeout)
                    w_state_nxt = S_RESP;
                else if (w_field_done)
                    w_state_nxt = S_MEM;
            end
            S_MEM: begin
                o_dbg_mem_op = 1'b1;
                o_dbg_wren   = r_is_write ? 4'hF : 4'h0;
                if (w_mem_done)
                    w_state_nxt = S_RESP;
            end
            S_RESP: begin
                o_tx_valid = 1'b1;
                if (w_resp_last)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt         <= 2'd0;
            r_is_write    <= 1'b0;
            r_asm         <= '0;
            r_adr_hold    <= '0;
            r_adr         <= '0;
            r_do          <= '0;
            r_mem_cnt     <= '0;
            r_resp        <= '0;
            r_resp_left   <= 2'd0;
            r_cpu_n_reset <= (HOLD_ON_RESET == 0);
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt     <= 2'd0;
                    r_mem_cnt <= '0;
                    if (i_rx_valid) begin
                        r_resp_left <= 2'd0;
                        case (i_rx_data)
                            CMD_W: r_is_write <= 1'b1;
                            CMD_R: r_is_write <= 1'b0;
                            CMD_G: begin
                                r_cpu_n_reset <= 1'b1;
                                r_resp        <= {24'd0, ACK};
                            end
                            CMD_H: begin
                                r_cpu_n_reset <= 1'b0;
                                r_resp        <= {24'd0, ACK};
                            end
                            default: r_resp <= {24'd0, NAK};
                        endcase
                    end
                end
                S_ADDR, S_DATA: begin
                    if (w_timeout) begin
                        r_resp      <= {24'd0, NAK};
                        r_resp_left <= 2'd0;
                    end else if (i_rx_valid) begin
                        r_asm <= w_asm_nxt;
                        r_cnt <= r_cnt + 2'd1;
                        // Bus outputs only change when an access is about to
                        // start, so a write keeps its address parked until
                        // the data field completes.
                        if (w_field_done) begin
                            if (r_state == S_DATA) begin
                                r_adr <= r_adr_hold;
                                r_do  <= w_asm_nxt;
                            end else if (r_is_write) begin
                                r_adr_hold <= w_asm_nxt;
                            end else begin
                                r_adr <= w_asm_nxt;
                            end
                        end
                    end
                end
                S_MEM: begin
                    if (w_mem_done) begin
                        r_mem_cnt <= '0;
                        if (r_is_write) begin
                            r_resp      <= {24'd0, ACK};
                            r_resp_left <= 2'd0;
                        end else begin
                            r_resp      <= i_dbg_di;
                            r_resp_left <= 2'd3;
                        end
                    end else begin
                        r_mem_cnt <= r_mem_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (w_tx_acc) begin
                        r_resp      <= {8'd0, r_resp[31:8]};
                        r_resp_left <= r_resp_left - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_tx_data     = r_resp[7:0];
    assign o_cpu_n_reset = r_cpu_n_reset;
    assign o_dbg_adr     = r_adr;
    assign o_dbg_do      = r_do;

endmodule

// File: tb/tb_dbg_loader.sv
module tb_dbg_loader;
    localparam int MC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        cpu_n_reset;
    logic        mem_op;
    logic [3:0]  wren;
    logic [31:0] adr;
    logic [31:0] dout;
    logic [31:0] dbg_di = 32'hDEADBEEF;

    always #5 clk = ~clk;

    dbg_loader #(.MEM_CYCLES(MC), .TIMEOUT_CYCLES(100), .HOLD_ON_RESET(1)) dut (
        .i_clk(clk), .i_reset(reset), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
        .o_cpu_n_reset(cpu_n_reset), .o_dbg_mem_op(mem_op), .o_dbg_wren(wren),
        .o_dbg_adr(adr), .o_dbg_do(dout), .i_dbg_di(dbg_di)
    );

    int total = 0;
    int bad = 0;

    // bus / tx monitor; also plays the memory, returning rd_val only on the
    // last cycle of each mem_op window
    int          mem_cnt = 0;
    int          win = 0;
    int          mem_unst = 0;
    int          tx_n = 0;
    logic [31:0] seen_adr = 0;
    logic [31:0] seen_do = 0;
    logic [3:0]  seen_wren = 0;
    logic [7:0]  tx_log [0:255];
    logic [31:0] rd_val = 0;

    always @(negedge clk) begin
        if (mem_op) begin
            if (win > 0 && (adr !== seen_adr || dout !== seen_do || wren !== seen_wren))
                mem_unst++;
            seen_adr = adr;
            seen_do = dout;
            seen_wren = wren;
            mem_cnt++;
            win++;
            dbg_di = (win == MC) ? rd_val : 32'hDEADBEEF;
        end else begin
            win = 0;
            dbg_di = 32'hDEADBEEF;
        end
        if (tx_valid && tx_ready) begin
            tx_log[tx_n[7:0]] = tx_data;
            tx_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #2;
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk); #2;
        rx_valid = 1'b0;
    endtask

    // wait until n bytes accepted since tx_base, then one edge so IDLE is back
    task automatic wait_tx(input string tag, input int base, input int n);
        for (int i = 0; i < 400 && (tx_n - base) < n; i++) @(posedge clk);
        chk(tag, tx_n - base, n);
        @(posedge clk); #2;
    endtask

    int tx_base;
    int mem_base;
    int unst;
    logic [7:0] h0;

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_mem_op", mem_op, 0);
        chk("rst_wren", wren, 0);
        chk("rst_adr", adr, 0);
        chk("rst_do", dout, 0);
        chk("rst_cpu", cpu_n_reset, 0);
        reset = 1'b0;

        // write 0x6F to 0x00020000
        tx_base = tx_n; mem_base = mem_cnt; unst = mem_unst;
        send(8'h57); send(8'h00); send(8'h00); send(8'h02); send(8'h00);
        send(8'h6F); send(8'h00); send(8'h00); send(8'h00);
        wait_tx("w_count", tx_base, 1);
        chk("w_resp", tx_log[tx_base[7:0]], 8'h06);
        chk("w_mem_cycles", mem_cnt - mem_base, MC);
        chk("w_adr", seen_adr, 32'h0002_0000);
        chk("w_do", seen_do, 32'h0000_006F);
        chk("w_wren", seen_wren, 4'hF);
        chk("w_stable", mem_unst - unst, 0);
        chk("w_cpu", cpu_n_reset, 0);
        chk("w_memop_after", mem_op, 0);
        chk("w_wren_after", wren, 0);
        chk("w_adr_kept", adr, 32'h0002_0000);
        chk("w_do_kept", dout, 32'h0000_006F);

        // read 0x00020004 returning 1
        rd_val = 32'h0000_0001;
        tx_base = tx_n; mem_base = mem_cnt; unst = mem_unst;
        send(8'h52); send(8'h04); send(8'h00); send(8'h02); send(8'h00);
        wait_tx("r_count", tx_base, 4);
        chk("r_b0", tx_log[tx_base[7:0]], 8'h01);
        chk("r_b1", tx_log[8'(tx_base + 1)], 8'h00);
        chk("r_b2", tx_log[8'(tx_base + 2)], 8'h00);
        chk("r_b3", tx_log[8'(tx_base + 3)], 8'h00);
        chk("r_mem_cycles", mem_cnt - mem_base, MC);
        chk("r_adr", seen_adr, 32'h0002_0004);
        chk("r_wren", seen_wren, 4'h0);
        chk("r_stable", mem_unst - unst, 0);
        chk("r_do_kept", dout, 32'h0000_006F);

        // G / H / unknown, then a back-to-back G
        tx_base = tx_n;
        send(8'h47);
        chk("g_cpu", cpu_n_reset, 1);
        wait_tx("g_count", tx_base, 1);
        chk("g_resp", tx_log[tx_base[7:0]], 8'h06);
        tx_base = tx_n;
        send(8'h48);
        chk("h_cpu", cpu_n_reset, 0);
        wait_tx("h_count", tx_base, 1);
        chk("h_resp", tx_log[tx_base[7:0]], 8'h06);
        tx_base = tx_n;
        send(8'h00);
        for (int i = 0; i < 50 && !tx_valid; i++) @(negedge clk);
        chk("nak_valid", tx_valid, 1);
        @(posedge clk); #2;            // byte accepted here, IDLE re-entered
        rx_data = 8'h47; rx_valid = 1'b1;
        @(posedge clk); #2;
        rx_valid = 1'b0;
        chk("b2b_cpu", cpu_n_reset, 1);
        wait_tx("b2b_count", tx_base, 2);
        chk("nak_resp", tx_log[tx_base[7:0]], 8'h15);
        chk("b2b_resp", tx_log[8'(tx_base + 1)], 8'h06);
        chk("idle_tx_valid", tx_valid, 0);
        tx_base = tx_n;
        send(8'h48);
        wait_tx("h2_count", tx_base, 1);
        chk("h2_cpu", cpu_n_reset, 0);

        // read with tx_ready low: output held, rx dropped
        tx_ready = 1'b0;
        rd_val = 32'hA1B2_C3D4;
        tx_base = tx_n; mem_base = mem_cnt;
        send(8'h52); send(8'h04); send(8'h00); send(8'h02); send(8'h00);
        for (int i = 0; i < 50 && !tx_valid; i++) @(negedge clk);
        chk("hold_valid", tx_valid, 1);
        h0 = tx_data;
        chk("hold_b0", h0, 8'hD4);
        unst = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== h0) unst++;
            if (i == 10) begin rx_data = 8'h47; rx_valid = 1'b1; end
            if (i == 20) begin rx_data = 8'h57; rx_valid = 1'b1; end
            if (i == 11 || i == 21) rx_valid = 1'b0;
        end
        chk("hold_stable", unst, 0);
        chk("hold_drop_cpu", cpu_n_reset, 0);
        @(posedge clk); #2;
        tx_ready = 1'b1;
        wait_tx("hold_count", tx_base, 4);
        chk("hold_b0r", tx_log[tx_base[7:0]], 8'hD4);
        chk("hold_b1", tx_log[8'(tx_base + 1)], 8'hC3);
        chk("hold_b2", tx_log[8'(tx_base + 2)], 8'hB2);
        chk("hold_b3", tx_log[8'(tx_base + 3)], 8'hA1);
        chk("hold_mem_cycles", mem_cnt - mem_base, MC);
        tx_base = tx_n;
        send(8'h00);
        wait_tx("post_hold_count", tx_base, 1);
        chk("post_hold_nak", tx_log[tx_base[7:0]], 8'h15);

        // reset in the middle of a write command
        tx_base = tx_n; mem_base = mem_cnt;
        send(8'h57); send(8'h00); send(8'h00);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk("rmid_mem", mem_cnt - mem_base, 0);
        chk("rmid_tx", tx_n - tx_base, 0);
        chk("rmid_tx_valid", tx_valid, 0);
        chk("rmid_cpu", cpu_n_reset, 0);
        send(8'h48);
        wait_tx("rmid_h_count", tx_base, 1);
        chk("rmid_h_resp", tx_log[tx_base[7:0]], 8'h06);
        chk("rmid_h_cpu", cpu_n_reset, 0);

`ifdef DBG_LOADER_TIMEOUT_EN
        // timeout during ADDR
        tx_base = tx_n; mem_base = mem_cnt;
        send(8'h57); send(8'h00);
        wait_tx("to_count", tx_base, 1);
        chk("to_resp", tx_log[tx_base[7:0]], 8'h15);
        chk("to_mem", mem_cnt - mem_base, 0);
`else
        // long gap inside ADDR must not abort the command
        rd_val = 32'h0000_0055;
        tx_base = tx_n; mem_base = mem_cnt;
        send(8'h52); send(8'h04);
        repeat (200) @(posedge clk);
        chk("gap_no_tx", tx_n - tx_base, 0);
        send(8'h00); send(8'h02); send(8'h00);
        wait_tx("gap_count", tx_base, 4);
        chk("gap_b0", tx_log[tx_base[7:0]], 8'h55);
        chk("gap_b1", tx_log[8'(tx_base + 1)], 8'h00);
        chk("gap_adr", seen_adr, 32'h0002_0004);
        chk("gap_mem", mem_cnt - mem_base, MC);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
